motor_seq: RTL

- Segment queue and bus-master sequencer for the motor register block.
- Buffers up to DEPTH linear segments. Each segment holds per-motor N/T, a motor mask and a task id.
- Drives the motor block's 16-bit write port: loads N/T for every motor, loads task_id, then fires the start strobe.
- Waits for every masked motor to report a free slot (wrreq) before writing, so the host can stream segments without polling.

---
 rtl/motor_seq.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/motor_seq.sv
// Segment queue and bus-master sequencer: buffers motion segments and replays each one
// into the motor register block as N/T loads, task id, then the start strobe.
module motor_seq #(
    parameter int          MOTORS = 4,
    parameter int          DEPTH  = 8,
    parameter logic [15:0] BAR    = 16'h0
) (
    input  logic                      clk,
    input  logic                      sclr,
    input  logic                      enable,
    input  logic                      abort,
    input  logic                      seg_valid,
    output logic                      seg_ready,
    input  logic [MOTORS-1:0]         seg_mask,
    input  logic [MOTORS*32-1:0]      seg_N,
    input  logic [MOTORS*32-1:0]      seg_T,
    input  logic [31:0]               seg_id,
    input  logic [MOTORS-1:0]         wrreq,
    output logic [15:0]               wraddr,
    output logic [1:0]                be,
    output logic                      write,
    output logic [15:0]               wrdata,
    output logic                      busy,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      seg_done
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              LW       = AW + 1;
    localparam logic [3:0]      LAST_IDX = 4'(4 * MOTORS - 1);
    localparam logic [LW-1:0]   FULL_LVL = LW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, WAIT_RDY, LOAD, ID_LO, ID_HI, FIRE, HOLD, ABORT
    } state_t;

    typedef struct packed {
        logic [MOTORS-1:0]    mask;
        logic [MOTORS*32-1:0] n;
        logic [MOTORS*32-1:0] t;
        logic [31:0]          id;
    } seg_t;

    seg_t           mem [DEPTH];
    seg_t           cur;
    state_t         state;
    logic [3:0]     idx;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [LW-1:0]  count;
    logic [LW-1:0]  next_count;
    logic           abort_take;
    logic           push;
    logic           pop;
    logic [127:0]   n_pad;
    logic [127:0]   t_pad;
    logic [6:0]     word_base;
    logic [15:0]    load_word;

    assign abort_take = abort && (state != ABORT);
    assign push       = seg_valid && seg_ready && !abort_take;
    assign level      = count;
    assign busy       = (state != IDLE) || (count != '0);

    // A pop happens on leaving IDLE, or on leaving the second HOLD cycle straight into WAIT_RDY.
    always_comb begin
        pop = 1'b0;
        if (!abort_take) begin
            if (state == IDLE)
                pop = enable && (count != '0);
            else if (state == HOLD && idx[0])
                pop = enable && (count != '0);
        end
    end

    always_comb begin
        next_count = count;
        if (abort_take)
            next_count = '0;
        else
            next_count = count + LW'(push) - LW'(pop);
    end

    // idx = {motor, word}; words 0/1 are N low/high, words 2/3 are T low/high.
    assign n_pad     = 128'(cur.n);
    assign t_pad     = 128'(cur.t);
    assign word_base = {idx[3:2], idx[0], 4'b0000};
    assign load_word = idx[1] ? t_pad[word_base +: 16] : n_pad[word_base +: 16];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {seg_mask, seg_N, seg_T, seg_id};
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            seg_ready <= 1'b0;
        end else begin
            count     <= next_count;
            seg_ready <= (next_count != FULL_LVL);
            if (abort_take) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + AW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Bus outputs are registered from the current state, so each write lags its state by a cycle.
    always_ff @(posedge clk) begin
        if (sclr) begin
            state    <= IDLE;
            idx      <= '0;
            cur      <= '0;
            write    <= 1'b0;
            wraddr   <= '0;
            wrdata   <= '0;
            be       <= '0;
            seg_done <= 1'b0;
        end else begin
            write    <= 1'b0;
            be       <= 2'b00;
            seg_done <= 1'b0;
            if (abort_take) begin
                state <= ABORT;
            end else begin
                case (state)
                    IDLE: begin
                        if (pop) begin
                            cur   <= mem[rd_ptr];
                            state <= WAIT_RDY;
                        end
                    end
                    WAIT_RDY: begin
                        if ((wrreq & cur.mask) == cur.mask) begin
                            idx   <= '0;
                            state <= LOAD;
                        end
                    end
                    LOAD: begin
                        write  <= 1'b1;
                        be     <= 2'b11;
                        wraddr <= BAR + {11'd0, idx, 1'b0};
                        wrdata <= load_word;
                        if (idx == LAST_IDX)
                            state <= ID_LO;
                        else
                            idx <= idx + 4'd1;
                    end
                    ID_LO: begin
                        write  <= 1'b1;
                        be     <= 2'b11;
                        wraddr <= BAR + 16'h0044;
                        wrdata <= cur.id[15:0];
                        state  <= ID_HI;
                    end
                    ID_HI: begin
                        write  <= 1'b1;
                        be     <= 2'b11;
                        wraddr <= BAR + 16'h0046;
                        wrdata <= cur.id[31:16];
                        state  <= FIRE;
                    end
                    FIRE: begin
                        write    <= 1'b1;
                        be       <= 2'b11;
                        wraddr   <= BAR + 16'h0048;
                        wrdata   <= 16'(cur.mask);
                        seg_done <= 1'b1;
                        idx      <= '0;
                        state    <= HOLD;
                    end
                    HOLD: begin
                        if (idx[0]) begin
                            if (pop) begin
                                cur   <= mem[rd_ptr];
                                state <= WAIT_RDY;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end
                    ABORT: begin
                        write  <= 1'b1;
                        be     <= 2'b01;
                        wraddr <= BAR + 16'h004A;
                        wrdata <= 16'h0002;
                        state  <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
